gfx_mask_arbiter: RTL and testbench

GFX_MASK_ARBITER -- requirements
Module: gfx_mask_arbiter

---
 rtl/gfx_defs_pkg.sv | 10 +
 rtl/gfx_mask_arbiter_pkg.sv | 9 +
 rtl/gfx_mask_rd_pipe.sv | 33 +++
 rtl/gfx_mask_arbiter.sv | 101 ++++++++++
 tb/tb_gfx_mask_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_defs_pkg.sv
// Shared graphics definitions: linear pixel coordinate type and system-wide
// mask RAM parameters.
package gfx_defs_pkg;

  localparam int GFX_LINEAR_RES      = 64;
  localparam int GFX_MASK_RD_LATENCY = 1;

  typedef logic [$clog2(GFX_LINEAR_RES)-1:0] linear_coord;

endpackage

// File: rtl/gfx_mask_arbiter_pkg.sv
// Local types for the mask arbiter: which of ROP/read won the last contested grant.
package gfx_mask_arbiter_pkg;

  typedef enum logic {
    GNT_ROP = 1'b0,
    GNT_RD  = 1'b1
  } grant_e;

endpackage

// File: rtl/gfx_mask_rd_pipe.sv
// Read-valid delay line and registered return data for the mask RAM read path.
module gfx_mask_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic rdata,
  output logic in_flight,
  output logic resp_valid,
  output logic resp_data
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages     <= '0;
      resp_valid <= 1'b0;
    end else begin
      stages     <= {stages[DEPTH-2:0], issue};
      resp_valid <= stages[DEPTH-1];
    end
  end

  // Captured every cycle; only meaningful alongside resp_valid.
  always_ff @(posedge clk) begin
    resp_data <= rdata;
  end

  assign in_flight = |stages;

endmodule

// File: rtl/gfx_mask_arbiter.sv
// Single-port mask RAM arbiter: clear has absolute priority, ROP and fragment
// reads share the remaining slots round-robin; RAM request is registered.
module gfx_mask_arbiter
  import gfx_defs_pkg::*;
  import gfx_mask_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = GFX_MASK_RD_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_valid,
  output logic        clr_ready,
  input  linear_coord clr_addr,
  input  logic        clr_data,
  input  logic        rop_valid,
  output logic        rop_ready,
  input  linear_coord rop_addr,
  input  logic        rop_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  linear_coord rd_addr,
  output logic        rd_resp_valid,
  output logic        rd_resp_data,
  output linear_coord mem_addr,
  output logic        mem_we,
  output logic        mem_wdata,
  input  logic        mem_rdata,
  output logic        busy
);

  grant_e last_grant;
  grant_e last_grant_next;
  logic   clr_xfer;
  logic   rop_xfer;
  logic   rd_xfer;
  logic   rd_in_flight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_RD;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    last_grant_next = last_grant;
    if (rop_xfer) begin
      last_grant_next = GNT_ROP;
    end else if (rd_xfer) begin
      last_grant_next = GNT_RD;
    end
  end

  always_comb begin
    clr_ready = clr_valid;
    rop_ready = !clr_valid && rop_valid && (!rd_valid || last_grant == GNT_RD);
    rd_ready  = !clr_valid && rd_valid && (!rop_valid || last_grant == GNT_ROP);
  end

  assign clr_xfer = clr_valid && clr_ready;
  assign rop_xfer = rop_valid && rop_ready;
  assign rd_xfer  = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we <= 1'b0;
    end else begin
      mem_we <= clr_xfer || rop_xfer;
    end
  end

  // Address/data carry no reset; mem_we alone qualifies a write.
  always_ff @(posedge clk) begin
    if (clr_xfer) begin
      mem_addr  <= clr_addr;
      mem_wdata <= clr_data;
    end else if (rop_xfer) begin
      mem_addr  <= rop_addr;
      mem_wdata <= rop_data;
    end else begin
      mem_addr  <= rd_addr;
      mem_wdata <= 1'b0;
    end
  end

  gfx_mask_rd_pipe #(
    .DEPTH(RD_LATENCY + 1)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (rd_xfer),
    .rdata      (mem_rdata),
    .in_flight  (rd_in_flight),
    .resp_valid (rd_resp_valid),
    .resp_data  (rd_resp_data)
  );

  assign busy = clr_valid || rop_valid || rd_valid || rd_in_flight;

endmodule

// File: tb/tb_gfx_mask_arbiter.sv
// Directed bench for gfx_mask_arbiter: two instances (read latency 1 and 2)
// share stimulus and are checked against a grant-order model every cycle.
module tb_gfx_mask_arbiter;
  import gfx_defs_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr_valid, clr_data, rop_valid, rop_data, rd_valid;
  linear_coord clr_addr, rop_addr, rd_addr;

  logic [1:0]  clr_ready_o, rop_ready_o, rd_ready_o;
  logic [1:0]  rd_resp_valid_o, rd_resp_data_o;
  logic [1:0]  mem_we_o, mem_wdata_o, mem_rdata_i, busy_o;
  linear_coord mem_addr_o [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = g + 1;
    logic       ram [GFX_LINEAR_RES] = '{default: 1'b0};
    logic [L-1:0] rdq;

    gfx_mask_arbiter #(.RD_LATENCY(L)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr_valid     (clr_valid),
      .clr_ready     (clr_ready_o[g]),
      .clr_addr      (clr_addr),
      .clr_data      (clr_data),
      .rop_valid     (rop_valid),
      .rop_ready     (rop_ready_o[g]),
      .rop_addr      (rop_addr),
      .rop_data      (rop_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready_o[g]),
      .rd_addr       (rd_addr),
      .rd_resp_valid (rd_resp_valid_o[g]),
      .rd_resp_data  (rd_resp_data_o[g]),
      .mem_addr      (mem_addr_o[g]),
      .mem_we        (mem_we_o[g]),
      .mem_wdata     (mem_wdata_o[g]),
      .mem_rdata     (mem_rdata_i[g]),
      .busy          (busy_o[g])
    );

    // Single-port RAM with L cycles of read latency.
    always @(posedge clk) begin
      if (mem_we_o[g]) ram[mem_addr_o[g]] <= mem_wdata_o[g];
      for (int k = L - 1; k > 0; k--) rdq[k] <= rdq[k-1];
      rdq[0] <= ram[mem_addr_o[g]];
    end
    assign mem_rdata_i[g] = rdq[L-1];
  end

  // ---------------- model state ----------------
  typedef struct { int cyc; logic data; } iss_t;
  iss_t iq[$];
  int   ptr [2];
  logic mmem [GFX_LINEAR_RES];
  bit   mlast_rop;
  bit   exp_we, exp_rd;
  linear_coord exp_addr;
  logic exp_wdata;
  int   gl[$];
  int   cyc;
  int   lrc [2];
  logic lrd [2];
  int   resp_cnt [2];
  int   checks, errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit c, r, d, ev, pend;
    cyc++;
    if (!rst_n) begin
      mlast_rop = 1'b0;
      iq.delete();
      ptr[0] = 0;
      ptr[1] = 0;
      exp_we = 1'b0;
      exp_rd = 1'b0;
    end
    c = clr_valid;
    r = !c && rop_valid && (!rd_valid || !mlast_rop);
    d = !c && rd_valid && (!rop_valid || mlast_rop);
    for (int g = 0; g < 2; g++) begin
      chk("clr_ready", clr_ready_o[g], c);
      chk("rop_ready", rop_ready_o[g], r);
      chk("rd_ready", rd_ready_o[g], d);
      chk("mem_we", mem_we_o[g], exp_we);
      if (exp_we || exp_rd) chk("mem_addr", mem_addr_o[g], exp_addr);
      if (exp_we) chk("mem_wdata", mem_wdata_o[g], exp_wdata);
      ev = (ptr[g] < iq.size()) && (iq[ptr[g]].cyc + g + 3 == cyc);
      chk("rd_resp_valid", rd_resp_valid_o[g], ev);
      if (ev) begin
        chk("rd_resp_data", rd_resp_data_o[g], iq[ptr[g]].data);
        ptr[g]++;
      end
      pend = ptr[g] < iq.size();
      chk("busy", busy_o[g], clr_valid || rop_valid || rd_valid || pend);
      if (rd_resp_valid_o[g]) begin
        lrc[g] = cyc;
        lrd[g] = rd_resp_data_o[g];
        resp_cnt[g]++;
      end
    end
    if (!rst_n) return;
    exp_we = c || r;
    exp_rd = d;
    if (c) begin
      exp_addr = clr_addr; exp_wdata = clr_data; mmem[clr_addr] = clr_data; gl.push_back(1);
    end else if (r) begin
      exp_addr = rop_addr; exp_wdata = rop_data; mmem[rop_addr] = rop_data; gl.push_back(2);
      mlast_rop = 1'b1;
    end else if (d) begin
      exp_addr = rd_addr; iq.push_back('{cyc: cyc, data: mmem[rd_addr]}); gl.push_back(3);
      mlast_rop = 1'b0;
    end else begin
      gl.push_back(0);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic idle();
    clr_valid = 0; rop_valid = 0; rd_valid = 0;
  endtask

  initial begin
    int t_rd, cnt0, cnt1;
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < GFX_LINEAR_RES; i++) mmem[i] = 1'b0;
    mlast_rop = 0; exp_we = 0; exp_rd = 0; exp_addr = '0; exp_wdata = 0;
    ptr[0] = 0; ptr[1] = 0;
    lrc[0] = 0; lrc[1] = 0; lrd[0] = 0; lrd[1] = 0; resp_cnt[0] = 0; resp_cnt[1] = 0;
    rst_n = 0; idle();
    clr_addr = '0; clr_data = 0; rop_addr = '0; rop_data = 0; rd_addr = '0;

    // reset state
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_mem_we_l1", mem_we_o[0], 0);
      chk("rst_resp_l2", rd_resp_valid_o[1], 0);
      advance();
    end
    rst_n = 1;
    tick(2);

    // round-robin: ROP writes 20,22,24 with 1; reads of the previous ROP address
    rop_valid = 1; rd_valid = 1; rop_data = 1;
    for (int i = 0; i < 6; i++) begin
      rop_addr = linear_coord'(20 + i);
      rd_addr  = linear_coord'(19 + i);
      tick(1);
    end
    idle();
    begin
      int exp_seq [6] = '{2, 3, 2, 3, 2, 3};
      for (int i = 0; i < 6; i++) chk("rr_grant", gl[gl.size() - 6 + i], exp_seq[i]);
    end
    tick(6);
    chk("rr_last_resp", lrd[1], 1);

    // clear priority over both ROP and read
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        clr_valid = 1; rop_valid = 1; rd_valid = 1;
        clr_addr = linear_coord'(i); clr_data = 0;
      end else begin
        idle();
      end
      sample();
      if (i < 4) begin
        chk("clr_pri_clr_ready", clr_ready_o[0], 1);
        chk("clr_pri_rop_ready", rop_ready_o[0], 0);
        chk("clr_pri_rd_ready", rd_ready_o[1], 0);
      end
      if (i > 0) begin
        chk("clr_pri_we", mem_we_o[0], 1);
        chk("clr_pri_addr", mem_addr_o[1], i - 1);
      end
      advance();
    end
    tick(2);

    // read latency: addr 5 holds 1
    rop_valid = 1; rop_addr = 5; rop_data = 1;
    tick(1);
    idle();
    tick(2);
    rd_valid = 1; rd_addr = 5;
    sample();
    t_rd = cyc;
    advance();
    idle();
    tick(6);
    chk("lat_l1_cycles", lrc[0] - t_rd, 3);
    chk("lat_l1_data", lrd[0], 1);
    chk("lat_l2_cycles", lrc[1] - t_rd, 4);

    // write then read same address on the next cycle
    rop_valid = 1; rop_addr = 9; rop_data = 1;
    tick(1);
    rop_valid = 0; rd_valid = 1; rd_addr = 9;
    tick(1);
    idle();
    tick(6);
    chk("wr_rd_l1", lrd[0], 1);
    chk("wr_rd_l2", lrd[1], 1);

    // full-range clear to 1
    clr_valid = 1; clr_data = 1;
    for (int i = 0; i < GFX_LINEAR_RES; i++) begin
      clr_addr = linear_coord'(i);
      tick(1);
    end
    idle();
    rd_valid = 1; rd_addr = 0;
    tick(1);
    idle();
    tick(6);
    chk("full_clr_addr0", lrd[0], 1);
    rd_valid = 1; rd_addr = linear_coord'(GFX_LINEAR_RES - 1);
    tick(1);
    idle();
    tick(6);
    chk("full_clr_addr_max", lrd[1], 1);

    // back-to-back reads return in order: 7 -> 0, 0 -> 1, 7 -> 0
    rop_valid = 1; rop_addr = 7; rop_data = 0;
    tick(1);
    idle();
    rd_valid = 1;
    rd_addr = 7; tick(1);
    rd_addr = 0; tick(1);
    rd_addr = 7; tick(1);
    idle();
    tick(7);
    chk("b2b_last_data", lrd[0], 0);

    // reset with two reads in flight
    rd_valid = 1; rd_addr = 1;
    tick(2);
    idle();
    cnt0 = resp_cnt[0];
    cnt1 = resp_cnt[1];
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_mid_we", mem_we_o[1], 0);
      advance();
    end
    rst_n = 1;
    tick(10);
    chk("rst_drop_l1", resp_cnt[0] - cnt0, 0);
    chk("rst_drop_l2", resp_cnt[1] - cnt1, 0);

    // ROP wins first tie after reset
    rop_valid = 1; rd_valid = 1; rop_addr = 3; rop_data = 1; rd_addr = 3;
    sample();
    chk("post_rst_rop_first", rop_ready_o[0], 1);
    advance();
    tick(1);
    idle();
    tick(6);
    chk("post_rst_rd_data", lrd[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
